lsu_dmem_master: RTL and testbench

Load/store unit sitting between the single-cycle core's execute stage and `dmem`. It accepts one load or store request at a time and drives `dmem`'s word address, byte-lane write data and 4-bit byte write enables. It captures `dmem`'s combinational read data and returns an aligned, sign- or zero-extended load result. Accesses that cross a 32-bit word boundary are split into two consecutive word accesses by an internal state machine.

---
 rtl/lsu_dmem_master.sv | 112 +++++++++++
 tb/tb_lsu_dmem_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store unit driving a word-wide dmem, splitting word-crossing
// accesses into two consecutive word accesses and returning aligned, extended load data.
module lsu_dmem_master #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] daddr_o,
    output logic [31:0] dwdata_o,
    output logic [3:0]  dwe_o,
    input  logic [31:0] drdata_i
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [2:0]  f3_q;
    logic        we_q, err_q, err_d, bad;
    logic [63:0] buf_q, buf_d, wide;
    logic [31:0] sh;
    logic [7:0]  mask_q, mask_in;

    function automatic logic [7:0] mask_of(input logic [2:0] f3, input logic [1:0] off);
        mask_of = (f3[1:0] == 2'd0 ? 8'h01 : f3[1:0] == 2'd1 ? 8'h03 : 8'h0F) << off;
    endfunction

    function automatic logic legal(input logic we, input logic [2:0] f3);
        legal = we ? (!f3[2] && f3[1:0] != 2'd3) : (f3[1:0] != 2'd3 && !(f3[2] && f3[1]));
    endfunction

    assign mask_in     = mask_of(req_funct3_i, req_addr_i[1:0]);
    assign mask_q      = mask_of(f3_q, addr_q[1:0]);
    assign wide        = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        daddr_o  = '0;
        dwdata_o = '0;
        dwe_o    = '0;
        bad      = !legal(req_we_i, req_funct3_i) || (!ALLOW_MISALIGNED && |mask_in[7:4]);
        case (state_q)
            IDLE: if (req_valid_i) begin
                state_d = bad ? RESP : ACC0;
                rdata_d = bad ? 32'b0 : rdata_q;
                err_d   = bad ? 1'b1 : err_q;
            end
            ACC0: begin
                daddr_o  = {addr_q[31:2], 2'b00};
                dwe_o    = we_q ? mask_q[3:0] : 4'b0;
                dwdata_o = wide[31:0];
                buf_d    = {32'b0, drdata_i};
                state_d  = |mask_q[7:4] ? ACC1 : RESP;
            end
            ACC1: begin
                daddr_o  = {addr_q[31:2], 2'b00} + 32'd4;
                dwe_o    = we_q ? mask_q[7:4] : 4'b0;
                dwdata_o = wide[63:32];
                buf_d    = {drdata_i, buf_q[31:0]};
                state_d  = RESP;
            end
            RESP: state_d = IDLE;
        endcase
        // The result register loads on the edge that completes the last memory access.
        sh = 32'(buf_d >> {addr_q[1:0], 3'b000});
        if ((state_q == ACC0 || state_q == ACC1) && state_d == RESP) begin
            err_d   = 1'b0;
            rdata_d = we_q ? 32'b0 :
                      f3_q[1:0] == 2'd0 ? {{24{sh[7] & ~f3_q[2]}}, sh[7:0]} :
                      f3_q[1:0] == 2'd1 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : sh;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                f3_q    <= req_funct3_i;
                we_q    <= req_we_i;
            end
        end
    end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed checks of lsu_dmem_master against a byte-array dmem,
// with a second instance built to reject word-crossing accesses.
module tb_lsu_dmem_master;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, v1 = 1'b0, we = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] a = '0, wd = '0;
    logic        rdy0, rv0, er0, rdy1, rv1, er1;
    logic [31:0] rd0, da0, dw0, rd1, da1, dw1;
    logic [3:0]  dwe0, dwe1;
    logic [31:0] dr0 = '0;
    wire  [31:0] dr1;
    logic [7:0]  mem [0:255];
    int          checks = 0, errors = 0;
    bit          bad0 = 1'b0;
    logic [31:0] a0_addr, a0_data, a1_addr, a1_data;
    logic [3:0]  a0_we, a1_we;
    logic        a0_rdy;

    lsu_dmem_master #(.ALLOW_MISALIGNED(1'b0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we),
        .req_funct3_i(f3), .req_addr_i(a), .req_wdata_i(wd), .rsp_valid_o(rv0),
        .rsp_rdata_o(rd0), .rsp_err_o(er0), .daddr_o(da0), .dwdata_o(dw0), .dwe_o(dwe0),
        .drdata_i(dr0));

    lsu_dmem_master u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we),
        .req_funct3_i(f3), .req_addr_i(a), .req_wdata_i(wd), .rsp_valid_o(rv1),
        .rsp_rdata_o(rd1), .rsp_err_o(er1), .daddr_o(da1), .dwdata_o(dw1), .dwe_o(dwe1),
        .drdata_i(dr1));

    assign dr1 = {mem[8'(da1[7:0] + 8'd3)], mem[8'(da1[7:0] + 8'd2)],
                  mem[8'(da1[7:0] + 8'd1)], mem[da1[7:0]]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (dwe1[i]) mem[8'(da1[7:0] + 8'(i))] = dw1[8*i +: 8];
        if (dwe0 != 4'b0) bad0 = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit sel, input logic w, input logic [2:0] f, input logic [31:0] ad,
                          input logic [31:0] d, output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        we = w; f3 = f; a = ad; wd = d;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        lat = 0; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin a0_addr = da1; a0_we = dwe1; a0_data = dw1; a0_rdy = rdy1; end
            if (k == 2) begin a1_addr = da1; a1_we = dwe1; a1_data = dw1; end
            if (sel ? rv1 : rv0) begin
                lat = k; rd = sel ? rd1 : rd0; er = sel ? er1 : er0;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic er;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h12345678;
        mem[8'h23] = 8'h80;
        mem[8'h03] = 8'h34; mem[8'h04] = 8'h92; mem[8'h05] = 8'h11;
        mem[8'h0A] = 8'h55; mem[8'h0B] = 8'h66;
        mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", rdy1, 1); check("rst_valid", rv1, 0); check("rst_rdata", rd1, 0);
        check("rst_err", er1, 0); check("rst_dwe", dwe1, 0); check("rst_daddr", da1, 0);
        check("rst_dwdata", dw1, 0); check("rst_ready0", rdy0, 1);
        @(negedge clk) rst_n = 1'b1;

        do_req(1, 0, 3'b010, 32'h10, 0, lat, rd, er);
        check("lw_lat", 32'(lat), 2); check("lw_a0_addr", a0_addr, 32'h10); check("lw_a0_we", a0_we, 0);
        check("lw_busy_ready", a0_rdy, 0); check("lw_rdata", rd, 32'h12345678); check("lw_err", er, 0);

        do_req(1, 0, 3'b000, 32'h23, 0, lat, rd, er);
        check("lb_lat", 32'(lat), 2); check("lb_rdata", rd, 32'hFFFFFF80);
        do_req(1, 0, 3'b100, 32'h23, 0, lat, rd, er);
        check("lbu_rdata", rd, 32'h00000080);
        do_req(1, 0, 3'b101, 32'h12, 0, lat, rd, er);
        check("lhu_rdata", rd, 32'h00001234);
        do_req(1, 0, 3'b001, 32'h11, 0, lat, rd, er);
        check("lh_off1_lat", 32'(lat), 2); check("lh_off1_rdata", rd, 32'h00003456);

        do_req(1, 0, 3'b001, 32'h03, 0, lat, rd, er);
        check("lh_x_lat", 32'(lat), 3); check("lh_x_rdata", rd, 32'hFFFF9234); check("lh_x_err", er, 0);
        do_req(0, 0, 3'b001, 32'h03, 0, lat, rd, er);
        check("lh_rej_lat", 32'(lat), 1); check("lh_rej_err", er, 1); check("lh_rej_rdata", rd, 0);

        do_req(1, 1, 3'b010, 32'h06, 32'hAABBCCDD, lat, rd, er);
        check("sw_lat", 32'(lat), 3);
        check("sw_a0_addr", a0_addr, 32'h04); check("sw_a0_we", a0_we, 4'b1100);
        check("sw_a0_data", a0_data, 32'hCCDD0000);
        check("sw_a1_addr", a1_addr, 32'h08); check("sw_a1_we", a1_we, 4'b0011);
        check("sw_a1_data", a1_data, 32'h0000AABB);
        check("sw_rdata", rd, 0); check("sw_err", er, 0);
        do_req(1, 0, 3'b010, 32'h04, 0, lat, rd, er);
        check("rb_lw4", rd, 32'hCCDD1192);
        do_req(1, 0, 3'b010, 32'h08, 0, lat, rd, er);
        check("rb_lw8", rd, 32'h6655AABB);

        do_req(1, 1, 3'b100, 32'h10, 32'hFFFFFFFF, lat, rd, er);
        check("st_bad_lat", 32'(lat), 1); check("st_bad_err", er, 1); check("st_bad_we", a0_we, 0);
        @(negedge clk);
        check("st_bad_ready", rdy1, 1); check("st_bad_hold_err", er1, 1);
        check("st_bad_mem", {24'b0, mem[8'h10]}, 32'h78);
        do_req(1, 0, 3'b011, 32'h10, 0, lat, rd, er);
        check("ld_bad_lat", 32'(lat), 1); check("ld_bad_err", er, 1); check("ld_bad_rdata", rd, 0);

        do_req(1, 0, 3'b010, 32'hFFFFFFFE, 0, lat, rd, er);
        check("wrap_lat", 32'(lat), 3); check("wrap_a0_addr", a0_addr, 32'hFFFFFFFC);
        check("wrap_a1_addr", a1_addr, 32'h0); check("wrap_rdata", rd, 32'hD4C3B2A1);

        mem[8'h06] = 8'h01; mem[8'h07] = 8'h02; mem[8'h08] = 8'h03; mem[8'h09] = 8'h04;
        @(negedge clk);
        we = 1'b1; f3 = 3'b010; a = 32'h06; wd = 32'hAABBCCDD; v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        check("rst_acc1_we", dwe1, 4'b0011);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dwe", dwe1, 0); check("rst_mid_valid", rv1, 0);
        check("rst_mid_ready", rdy1, 1); check("rst_mid_daddr", da1, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rv1) seen = 1'b1;
        end
        check("rst_no_rsp", seen, 0);
        check("rst_mem6", {24'b0, mem[8'h06]}, 32'hDD); check("rst_mem7", {24'b0, mem[8'h07]}, 32'hCC);
        check("rst_mem8", {24'b0, mem[8'h08]}, 32'h03); check("rst_mem9", {24'b0, mem[8'h09]}, 32'h04);
        check("rej_dwe_never", bad0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
